// File: rtl/dmux_16_stream_if.sv
// Handshake bundle for dmux_16_stream: producer port, two consumer ports, debug counters.
// Define DMUX_PARITY_EN to add the a_par/b_par parity outputs.
interface dmux_16_stream_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic             cnt_clr;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;
`ifdef DMUX_PARITY_EN
  logic             a_par;
  logic             b_par;
`endif

  // master: the producer/consumer environment; slave: the demux itself
  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready, cnt_clr,
    input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
`ifdef DMUX_PARITY_EN
    , input a_par, b_par
`endif
  );

  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready, cnt_clr,
    output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
`ifdef DMUX_PARITY_EN
    , output a_par, b_par
`endif
  );
endinterface

// File: rtl/dmux_16_stream.sv
// 1-to-2 stream demultiplexer with a one-entry holding slot and a transfer counter per destination.
// Define DMUX_PARITY_EN to register even parity alongside each held word.
module dmux_16_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmux_16_stream_if.slave bus
);
  logic [WIDTH-1:0] a_data_q, b_data_q;
  logic             a_valid_q, b_valid_q;
  logic [CNT_W-1:0] a_count_q, b_count_q;
  logic             acc_a, acc_b, drain_a, drain_b;

  // A slot can take a new word if it is empty or being drained this same edge
  assign bus.in_ready = bus.in_sel ? (!b_valid_q || bus.b_ready)
                                   : (!a_valid_q || bus.a_ready);

  assign acc_a   = bus.in_valid && bus.in_ready && !bus.in_sel;
  assign acc_b   = bus.in_valid && bus.in_ready &&  bus.in_sel;
  assign drain_a = a_valid_q && bus.a_ready;
  assign drain_b = b_valid_q && bus.b_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else begin
      if (acc_a) begin
        a_valid_q <= 1'b1;
        a_data_q  <= bus.in_data;
      end else if (drain_a) begin
        a_valid_q <= 1'b0;
      end
      if (acc_b) begin
        b_valid_q <= 1'b1;
        b_data_q  <= bus.in_data;
      end else if (drain_b) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle handshake; counters wrap naturally
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (drain_a) a_count_q <= a_count_q + 1'b1;
      if (drain_b) b_count_q <= b_count_q + 1'b1;
    end
  end

`ifdef DMUX_PARITY_EN
  logic a_par_q, b_par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_par_q <= 1'b0;
      b_par_q <= 1'b0;
    end else begin
      if (acc_a) a_par_q <= ^bus.in_data;
      if (acc_b) b_par_q <= ^bus.in_data;
    end
  end

  assign bus.a_par = a_par_q;
  assign bus.b_par = b_par_q;
`endif

  assign bus.a_data  = a_data_q;
  assign bus.b_data  = b_data_q;
  assign bus.a_valid = a_valid_q;
  assign bus.b_valid = b_valid_q;
  assign bus.a_count = a_count_q;
  assign bus.b_count = b_count_q;
endmodule

// File: tb/tb_dmux_16_stream.sv
// Scoreboard bench for dmux_16_stream: accepted words are queued per destination,
// a negedge monitor pops and compares on every output handshake.
module tb_dmux_16_stream;
  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  dmux_16_stream_if #(.WIDTH(16), .CNT_W(8)) bus ();

  dmux_16_stream #(.WIDTH(16), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.a_valid && bus.a_ready) begin
        if (qa.size() == 0) chk("a_unexpected_word", bus.a_data, 32'hDEAD_0000);
        else                chk("a_data", bus.a_data, qa.pop_front());
      end
      if (bus.b_valid && bus.b_ready) begin
        if (qb.size() == 0) chk("b_unexpected_word", bus.b_data, 32'hDEAD_0001);
        else                chk("b_data", bus.b_data, qb.pop_front());
      end
    end
  end

  // Producer protocol: a pending word must hold data and select stable
  logic        pend = 1'b0;
  logic [15:0] pd;
  logic        ps;
  always @(posedge clk) begin
    if (pend && bus.in_valid && (bus.in_data !== pd || bus.in_sel !== ps))
      $error("producer changed a pending word");
    pend = bus.in_valid && !bus.in_ready && !reset;
    pd   = bus.in_data;
    ps   = bus.in_sel;
  end

  // Leaves in_valid high; caller deasserts once its burst is done
  task automatic send(input logic [15:0] d, input logic s);
    bit done = 0;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (s) qb.push_back(d);
        else   qa.push_back(d);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_data  = '0;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.cnt_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_a_valid", bus.a_valid, 0);
    chk("rst_b_valid", bus.b_valid, 0);
    chk("rst_a_count", bus.a_count, 0);
    chk("rst_b_count", bus.b_count, 0);
    chk("rst_a_data",  bus.a_data,  0);
    chk("idle_ready_sel0", bus.in_ready, 1);
    bus.in_sel = 1'b1; #1;
    chk("idle_ready_sel1", bus.in_ready, 1);
    @(posedge clk); #1;

    // A stalls; a second A word must be refused while B still flows
    send(16'hA5A5, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("a_valid_held", bus.a_valid, 1);
    chk("a_data_held",  bus.a_data,  16'hA5A5);
    bus.in_sel = 1'b0; #1;
    chk("a_full_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    send(16'h1234, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b_valid_held", bus.b_valid, 1);
    chk("b_data_held",  bus.b_data,  16'h1234);
    chk("a_still_held", bus.a_data,  16'hA5A5);
    chk("no_count_a", bus.a_count, 0);

    // Reset with both slots full discards the held words
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    chk("midrst_a_valid", bus.a_valid, 0);
    chk("midrst_b_valid", bus.b_valid, 0);
    chk("midrst_a_data",  bus.a_data,  0);
    chk("midrst_b_data",  bus.b_data,  0);
    @(posedge clk); #1;

    // 600 alternating words at full rate: 300 per side, wrapping 8-bit counters to 44
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    for (int i = 0; i < 600; i++)
      send(16'(i * 16'h0101) ^ 16'h5A00, 1'(i % 2));
    idle(3);
    @(negedge clk);
    chk("stream_a_count", bus.a_count, 44);
    chk("stream_b_count", bus.b_count, 44);
    chk("stream_qa_empty", qa.size(), 0);
    chk("stream_qb_empty", qb.size(), 0);
    @(posedge clk); #1;

    // Drain and accept on the same slot in one cycle
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    send(16'hBEEF, 1'b0);
    bus.a_ready = 1'b1;
    send(16'hCAFE, 1'b0);
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    @(negedge clk);
    chk("bypass_a_valid", bus.a_valid, 1);
    chk("bypass_a_data",  bus.a_data,  16'hCAFE);
    chk("bypass_a_count", bus.a_count, 45);

    // Clear coincides with an A handshake: the handshake is not counted
    @(posedge clk); #1;
    bus.a_ready = 1'b1;
    bus.cnt_clr = 1'b1;
    @(posedge clk); #1;
    bus.cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_a_count", bus.a_count, 0);
    chk("clr_b_count", bus.b_count, 0);
    chk("clr_a_valid", bus.a_valid, 0);
    @(posedge clk); #1;

    // One more handshake after clear counts from zero
    send(16'h0F0F, 1'b0);
    idle(2);
    @(negedge clk);
    chk("post_clr_a_count", bus.a_count, 1);

`ifdef DMUX_PARITY_EN
    @(posedge clk); #1;
    bus.a_ready = 1'b0;
    send(16'h0001, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("a_par_odd", bus.a_par, 1);
    @(posedge clk); #1;
    bus.a_ready = 1'b1;
    send(16'h0003, 1'b0);
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    @(negedge clk);
    chk("a_par_even", bus.a_par, 0);
    @(posedge clk); #1;
    bus.a_ready = 1'b1;
    idle(2);
`endif

    @(negedge clk);
    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
